target_controller: RTL and testbench
====================================

TARGET_CONTROLLER -- requirements
Module: target_controller

Interface
REQ-001 The block SHALL have parameter TARGET_FRAMES, default 90, which sets the frames a target stays live before it counts as missed.
REQ-002 The block SHALL have parameter GAME_TARGETS, default 20, which sets the targets per game (hit plus missed).
REQ-003 The block SHALL have parameter LFSR_SEED, default 16'hACE1, which is the non-zero LFSR reset value.
REQ-004 The block SHALL have port clk, input, 1 bit: the 25 MHz VGA clock, which is the only clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port start_btn, input, 1 bit: debounced one-cycle start pulse.
REQ-007 The block SHALL have port frame_tick, input, 1 bit: one-cycle pulse per VGA frame.
REQ-008 The block SHALL have port click, input, 1 bit: one-cycle mouse-click pulse.
REQ-009 The block SHALL have ports mouse_x and mouse_y, input, 10 bits each: pointer position in pixels.
REQ-010 The block SHALL have ports ballX and ballY, output, 10 bits each: target top-left corner, consumed by ball_display.
REQ-011 The block SHALL have port start, output, 1 bit: high only while a target is live; drives ball_display start.
REQ-012 The block SHALL have ports score and misses, output, 8 bits each: hit and timeout counts, saturating at 255.
REQ-013 The block SHALL have port game_over, output, 1 bit: high while in state OVER.

Function
REQ-014 The FSM SHALL have the states IDLE, PLACE, ACTIVE and OVER.
REQ-015 In IDLE or OVER, start_btn SHALL move the FSM to PLACE and, in that same cycle, clear score, misses and the target counter.
REQ-016 start_btn SHALL be ignored while in PLACE or ACTIVE.
REQ-017 The 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every clock cycle while rst_n is high, regardless of FSM state.
REQ-018 In PLACE, every cycle SHALL form the candidates cx = lfsr[9:0] and cy = lfsr[15:6].
REQ-019 In PLACE, a candidate pair SHALL be accepted only if cx <= 599 and cy <= 439; otherwise PLACE retries on the next cycle.
REQ-020 On acceptance, ballX and ballY SHALL register cx and cy, the frame timer SHALL clear, and the FSM SHALL enter ACTIVE on the next cycle.
REQ-021 ballX and ballY SHALL hold their values in every state except the PLACE acceptance cycle.
REQ-022 A hit SHALL be click in ACTIVE with ballX < mouse_x < ballX+40 and ballY < mouse_y < ballY+40, using strict bounds and 10-bit compares identical to the display window.
REQ-023 A hit SHALL increment score and the target counter.
REQ-024 In ACTIVE, each frame_tick SHALL increment the frame timer.
REQ-025 A timeout SHALL occur on a frame_tick when the timer equals TARGET_FRAMES-1; it SHALL increment misses and the target counter.
REQ-026 After a hit or timeout, the FSM SHALL go to OVER if the target counter has reached GAME_TARGETS, otherwise to PLACE.
REQ-027 If a hit and a timeout occur in the same cycle, the hit SHALL win and exactly one counter SHALL increment.
REQ-028 A click outside the window SHALL have no effect.
REQ-029 click outside ACTIVE SHALL be ignored.
REQ-030 start SHALL be registered and equal 1 exactly during ACTIVE cycles.
REQ-031 game_over SHALL be registered and equal 1 exactly during OVER cycles.
REQ-032 score and misses SHALL hold at 255 when incremented from 255.
REQ-033 score and misses SHALL hold their values in OVER until the next start_btn.

Reset
REQ-034 While rst_n is 0, the state SHALL be IDLE, lfsr SHALL be LFSR_SEED, and ballX, ballY, score, misses, start, game_over, the frame timer and the target counter SHALL all be 0.
REQ-035 Reset asserted mid-game SHALL abort immediately to IDLE with the values of REQ-034, and no partial count SHALL survive.

Structure
REQ-036 The shared package SHALL hold BALL_SIZE=40, MAX_X=599, MAX_Y=439 and the FSM state enum.
REQ-037 BALL_SIZE in the shared package SHALL be the value ball_display also uses.
REQ-038 The LFSR SHALL be a sub-module named target_lfsr (inputs clk, rst_n; output 16-bit value; seed parameter).
REQ-039 The hit comparator and the FSM SHALL remain in target_controller.

Verification
REQ-040 The bench SHALL cover reset: rst_n low -> all outputs 0, game_over 0, lfsr equals 16'hACE1.
REQ-041 The bench SHALL cover a hit: start_btn, wait for start=1 with ballX=X, ballY=Y, then click at (X+20, Y+20) -> score=1, misses=0, start drops for at least 1 cycle, then a new placement with ballX <= 599 and ballY <= 439.
REQ-042 The bench SHALL cover an edge miss: click at (X, Y+20) and at (X+40, Y+20) -> no count change and ACTIVE held.
REQ-043 The bench SHALL cover a timeout: no clicks, 90 frame_ticks -> misses=1 on the 90th tick; a same-cycle inside click plus the 90th tick -> score=1, misses=0.
REQ-044 The bench SHALL cover game end: 20 targets (10 hits, 10 timeouts) -> game_over=1, start=0, score=10, misses=10; a further start_btn -> counts 0 and PLACE entered.
REQ-045 The bench SHALL cover reset mid-ACTIVE with score=5: rst_n pulse -> IDLE and all counts 0.
REQ-046 The bench SHALL cover start_btn during ACTIVE: no effect on any output.

Source files
------------

// File: rtl/target_controller_pkg.sv
// Shared constants and types for the aim-trainer target logic.
// BALL_SIZE must match the value ball_display uses to draw the target.
// MAX_X/MAX_Y are the largest top-left coordinates that still keep the
// whole target inside the 640x480 visible area.
package target_controller_pkg;

  localparam int unsigned BALL_SIZE = 40;
  localparam int unsigned MAX_X     = 599;
  localparam int unsigned MAX_Y     = 439;

  typedef enum logic [1:0] {
    IDLE,
    PLACE,
    ACTIVE,
    OVER
  } state_t;

  // Increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/target_controller_lfsr.sv
// target_lfsr: free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset, loads SEED
//   value - current LFSR state
// SEED must be non-zero or the register locks up at zero.
module target_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] value
);

  logic feedback;

  // Bit n of the tap list is value[n-1].
  assign feedback = value[15] ^ value[13] ^ value[12] ^ value[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else begin
      value <= {value[14:0], feedback};
    end
  end

endmodule

// File: rtl/target_controller.sv
// target_controller: game FSM for a click-the-target game.
// A target is placed at a pseudo-random on-screen position, stays live
// for TARGET_FRAMES frames, and is scored as a hit if clicked inside its
// window or as a miss on timeout. After GAME_TARGETS targets the game ends.
// Ports:
//   clk, rst_n       - 25 MHz pixel clock, async active-low reset
//   start_btn        - one-cycle start pulse (honoured in IDLE/OVER only)
//   frame_tick       - one-cycle pulse per video frame
//   click            - one-cycle mouse click pulse
//   mouse_x, mouse_y - pointer position
//   ballX, ballY     - target top-left corner
//   start            - high exactly while a target is live
//   score, misses    - hit and timeout counts, saturating at 255
//   game_over        - high while the game has ended
module target_controller
  import target_controller_pkg::*;
#(
  parameter int unsigned   TARGET_FRAMES = 90,
  parameter int unsigned   GAME_TARGETS  = 20,
  parameter logic [15:0]   LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       frame_tick,
  input  logic       click,
  input  logic [9:0] mouse_x,
  input  logic [9:0] mouse_y,
  output logic [9:0] ballX,
  output logic [9:0] ballY,
  output logic       start,
  output logic [7:0] score,
  output logic [7:0] misses,
  output logic       game_over
);

  localparam int unsigned FW = $clog2(TARGET_FRAMES + 1);
  localparam int unsigned TW = $clog2(GAME_TARGETS + 1);

  localparam logic [9:0]    SIZE10    = 10'(BALL_SIZE);
  localparam logic [9:0]    MAX_X10   = 10'(MAX_X);
  localparam logic [9:0]    MAX_Y10   = 10'(MAX_Y);
  localparam logic [FW-1:0] LAST_FRM  = FW'(TARGET_FRAMES - 1);
  localparam logic [TW-1:0] ALL_TGTS  = TW'(GAME_TARGETS);

  state_t        state_q, state_d;
  logic [9:0]    ball_x_q, ball_x_d;
  logic [9:0]    ball_y_q, ball_y_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    misses_q, misses_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [TW-1:0] tgt_q, tgt_d;
  logic          start_q, over_q;

  logic [15:0] lfsr;
  logic [9:0]  cx, cy;
  logic [9:0]  x_hi, y_hi;
  logic        cand_ok, in_win, hit, timeout;

  target_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .value (lfsr)
  );

  assign cx      = lfsr[9:0];
  assign cy      = lfsr[15:6];
  assign cand_ok = (cx <= MAX_X10) && (cy <= MAX_Y10);

  // Same strict, 10-bit window the display uses; ballX <= 599 so the
  // upper bound cannot wrap.
  assign x_hi    = ball_x_q + SIZE10;
  assign y_hi    = ball_y_q + SIZE10;
  assign in_win  = (mouse_x > ball_x_q) && (mouse_x < x_hi) &&
                   (mouse_y > ball_y_q) && (mouse_y < y_hi);
  assign hit     = click && in_win;
  assign timeout = frame_tick && (frame_q == LAST_FRM);

  always_comb begin
    state_d  = state_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    score_d  = score_q;
    misses_d = misses_q;
    frame_d  = frame_q;
    tgt_d    = tgt_q;
    case (state_q)
      IDLE, OVER: begin
        if (start_btn) begin
          state_d  = PLACE;
          score_d  = '0;
          misses_d = '0;
          tgt_d    = '0;
        end
      end
      PLACE: begin
        if (cand_ok) begin
          ball_x_d = cx;
          ball_y_d = cy;
          frame_d  = '0;
          state_d  = ACTIVE;
        end
      end
      ACTIVE: begin
        // A hit takes priority over a coincident timeout.
        if (hit || timeout) begin
          if (hit) begin
            score_d = sat_inc(score_q);
          end else begin
            misses_d = sat_inc(misses_q);
          end
          tgt_d   = tgt_q + TW'(1);
          state_d = (tgt_d == ALL_TGTS) ? OVER : PLACE;
        end else if (frame_tick) begin
          frame_d = frame_q + FW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ball_x_q <= '0;
      ball_y_q <= '0;
      score_q  <= '0;
      misses_q <= '0;
      frame_q  <= '0;
      tgt_q    <= '0;
      start_q  <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      frame_q  <= frame_d;
      tgt_q    <= tgt_d;
      start_q  <= (state_d == ACTIVE);
      over_q   <= (state_d == OVER);
    end
  end

  assign ballX     = ball_x_q;
  assign ballY     = ball_y_q;
  assign start     = start_q;
  assign score     = score_q;
  assign misses    = misses_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_target_controller.sv
// Directed bench for target_controller: reset, hit, window edges,
// start_btn while live, timeout and hit/timeout priority, mid-game reset,
// and a full 20-target game.
module tb_target_controller;
  import target_controller_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_btn = 1'b0;
  logic       frame_tick = 1'b0;
  logic       click = 1'b0;
  logic [9:0] mouse_x = '0;
  logic [9:0] mouse_y = '0;
  logic [9:0] ballX, ballY;
  logic       start;
  logic [7:0] score, misses;
  logic       game_over;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_lfsr;
  logic [9:0]  cur_x, cur_y;

  target_controller #(
    .TARGET_FRAMES (90),
    .GAME_TARGETS  (20),
    .LFSR_SEED     (16'hACE1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_btn  (start_btn),
    .frame_tick (frame_tick),
    .click      (click),
    .mouse_x    (mouse_x),
    .mouse_y    (mouse_y),
    .ballX      (ballX),
    .ballY      (ballY),
    .start      (start),
    .score      (score),
    .misses     (misses),
    .game_over  (game_over)
  );

  always #20 clk = ~clk;

  // Reference LFSR: x^16 + x^14 + x^13 + x^11, left-shifting Fibonacci form.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
  endtask

  task automatic do_click(input logic [9:0] x, input logic [9:0] y);
    mouse_x = x;
    mouse_y = y;
    click   = 1'b1;
    tick();
    click   = 1'b0;
  endtask

  task automatic frame_pulse();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick();
  endtask

  // Waits (bounded) for a live target and records its position.
  task automatic wait_active();
    int n = 0;
    while (start !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    n_checks++;
    if (start !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_active: start=%b after %0d cycles, required 1", start, n);
    end
    cur_x = ballX;
    cur_y = ballY;
    n_checks++;
    if (cur_x > 10'd599 || cur_y > 10'd439) begin
      n_fail++;
      $display("FAIL placement: ballX=%0d ballY=%0d, required <=599/<=439", cur_x, cur_y);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (start !== 1'b0)     begin n_fail++; $display("FAIL rst_start: got %b want 0", start); end
    n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL rst_over: got %b want 0", game_over); end
    n_checks++; if (score !== 8'd0)     begin n_fail++; $display("FAIL rst_score: got %0d want 0", score); end
    n_checks++; if (misses !== 8'd0)    begin n_fail++; $display("FAIL rst_misses: got %0d want 0", misses); end
    n_checks++; if (ballX !== 10'd0 || ballY !== 10'd0) begin n_fail++; $display("FAIL rst_ball: got %0d,%0d want 0,0", ballX, ballY); end
    n_checks++; if (dut.lfsr !== 16'hACE1) begin n_fail++; $display("FAIL rst_lfsr: got %h want ace1", dut.lfsr); end
    rst_n = 1'b1;
    repeat (5) tick();
    n_checks++; if (dut.lfsr !== m_lfsr) begin n_fail++; $display("FAIL lfsr_idle: got %h want %h", dut.lfsr, m_lfsr); end
    n_checks++; if (dut.state_q !== IDLE || start !== 1'b0) begin n_fail++; $display("FAIL idle_hold: state=%0d start=%b want IDLE,0", dut.state_q, start); end
  endtask

  task automatic test_hit();
    pulse_start();
    n_checks++; if (dut.state_q !== PLACE) begin n_fail++; $display("FAIL hit_place: state=%0d want PLACE", dut.state_q); end
    wait_active();
    do_click(cur_x + 10'd20, cur_y + 10'd20);
    n_checks++; if (score !== 8'd1)  begin n_fail++; $display("FAIL hit_score: got %0d want 1", score); end
    n_checks++; if (misses !== 8'd0) begin n_fail++; $display("FAIL hit_misses: got %0d want 0", misses); end
    n_checks++; if (start !== 1'b0)  begin n_fail++; $display("FAIL hit_start_drop: got %b want 0", start); end
    wait_active();
    n_checks++; if (dut.lfsr !== m_lfsr) begin n_fail++; $display("FAIL lfsr_run: got %h want %h", dut.lfsr, m_lfsr); end
  endtask

  task automatic test_edge_miss();
    do_click(cur_x, cur_y + 10'd20);
    n_checks++; if (score !== 8'd1 || misses !== 8'd0 || start !== 1'b1) begin n_fail++; $display("FAIL edge_left: score=%0d misses=%0d start=%b want 1,0,1", score, misses, start); end
    do_click(cur_x + 10'd40, cur_y + 10'd20);
    n_checks++; if (score !== 8'd1 || misses !== 8'd0 || start !== 1'b1) begin n_fail++; $display("FAIL edge_right: score=%0d misses=%0d start=%b want 1,0,1", score, misses, start); end
    do_click(cur_x + 10'd20, cur_y);
    n_checks++; if (score !== 8'd1 || misses !== 8'd0 || start !== 1'b1) begin n_fail++; $display("FAIL edge_top: score=%0d misses=%0d start=%b want 1,0,1", score, misses, start); end
    do_click(cur_x + 10'd20, cur_y + 10'd40);
    n_checks++; if (score !== 8'd1 || misses !== 8'd0 || start !== 1'b1) begin n_fail++; $display("FAIL edge_bottom: score=%0d misses=%0d start=%b want 1,0,1", score, misses, start); end
  endtask

  task automatic test_start_active();
    pulse_start();
    repeat (3) tick();
    n_checks++;
    if (score !== 8'd1 || misses !== 8'd0 || start !== 1'b1 || game_over !== 1'b0 ||
        ballX !== cur_x || ballY !== cur_y) begin
      n_fail++;
      $display("FAIL start_in_active: score=%0d misses=%0d start=%b over=%b ball=%0d,%0d want 1,0,1,0,%0d,%0d",
               score, misses, start, game_over, ballX, ballY, cur_x, cur_y);
    end
  endtask

  task automatic test_timeout();
    repeat (89) frame_pulse();
    n_checks++; if (misses !== 8'd0 || start !== 1'b1) begin n_fail++; $display("FAIL tmo_89: misses=%0d start=%b want 0,1", misses, start); end
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    n_checks++; if (misses !== 8'd1 || score !== 8'd1 || start !== 1'b0) begin n_fail++; $display("FAIL tmo_90: misses=%0d score=%0d start=%b want 1,1,0", misses, score, start); end
    wait_active();
    repeat (89) frame_pulse();
    mouse_x    = cur_x + 10'd20;
    mouse_y    = cur_y + 10'd20;
    click      = 1'b1;
    frame_tick = 1'b1;
    tick();
    click      = 1'b0;
    frame_tick = 1'b0;
    n_checks++; if (score !== 8'd2 || misses !== 8'd1) begin n_fail++; $display("FAIL hit_vs_tmo: score=%0d misses=%0d want 2,1", score, misses); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      wait_active();
      do_click(cur_x + 10'd1, cur_y + 10'd39);
    end
    n_checks++; if (score !== 8'd5) begin n_fail++; $display("FAIL mid_score5: got %0d want 5", score); end
    wait_active();
    rst_n = 1'b0;
    #5;
    n_checks++;
    if (score !== 8'd0 || misses !== 8'd0 || start !== 1'b0 || game_over !== 1'b0 ||
        ballX !== 10'd0 || ballY !== 10'd0 || dut.state_q !== IDLE || dut.lfsr !== 16'hACE1) begin
      n_fail++;
      $display("FAIL mid_reset: score=%0d misses=%0d start=%b over=%b ball=%0d,%0d state=%0d lfsr=%h want all 0, IDLE, ace1",
               score, misses, start, game_over, ballX, ballY, dut.state_q, dut.lfsr);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_game_end();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      wait_active();
      do_click(cur_x + 10'd39, cur_y + 10'd1);
    end
    for (int i = 0; i < 9; i++) begin
      wait_active();
      repeat (90) frame_pulse();
    end
    n_checks++; if (game_over !== 1'b0 || score !== 8'd10 || misses !== 8'd9) begin n_fail++; $display("FAIL game_19: over=%b score=%0d misses=%0d want 0,10,9", game_over, score, misses); end
    wait_active();
    repeat (89) frame_pulse();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    n_checks++;
    if (game_over !== 1'b1 || start !== 1'b0 || score !== 8'd10 || misses !== 8'd10) begin
      n_fail++;
      $display("FAIL game_end: over=%b start=%b score=%0d misses=%0d want 1,0,10,10", game_over, start, score, misses);
    end
    do_click(cur_x + 10'd20, cur_y + 10'd20);
    repeat (3) frame_pulse();
    n_checks++;
    if (game_over !== 1'b1 || start !== 1'b0 || score !== 8'd10 || misses !== 8'd10) begin
      n_fail++;
      $display("FAIL over_hold: over=%b start=%b score=%0d misses=%0d want 1,0,10,10", game_over, start, score, misses);
    end
    pulse_start();
    n_checks++;
    if (score !== 8'd0 || misses !== 8'd0 || game_over !== 1'b0 || dut.state_q !== PLACE) begin
      n_fail++;
      $display("FAIL restart: score=%0d misses=%0d over=%b state=%0d want 0,0,0,PLACE", score, misses, game_over, dut.state_q);
    end
    wait_active();
  endtask

  initial begin
    test_reset();
    test_hit();
    test_edge_miss();
    test_start_active();
    test_timeout();
    test_reset_mid();
    test_game_end();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
